// File: rtl/pixel_plot_writer.sv
// Pixel plot writer: clips and addresses incoming raster pixels, queues them and writes them to the
// framebuffer through a req/ack port. Define PIXEL_STATS_EN to add written/clipped counters.
module pixel_plot_writer #(
   parameter int H_RES      = 640,
   parameter int V_RES      = 480,
   parameter int ADDR_W     = 19,
   parameter int COLOR_W    = 8,
   parameter int FIFO_DEPTH = 8
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               frame_start,
   input  logic               px_valid,
   output logic               px_ready,
   input  logic [9:0]         px_x,
   input  logic [8:0]         px_y,
   input  logic [COLOR_W-1:0] px_color,
   input  logic               px_last,
   output logic               mem_req,
   output logic [ADDR_W-1:0]  mem_addr,
   output logic [COLOR_W-1:0] mem_data,
   input  logic               mem_ack,
   output logic               busy,
   output logic               done
`ifdef PIXEL_STATS_EN
   ,
   output logic [15:0]        written_cnt,
   output logic [15:0]        clipped_cnt
`endif
);

   localparam int PTR_W   = $clog2(FIFO_DEPTH);
   localparam int ENTRY_W = 2 + ADDR_W + COLOR_W;

   typedef enum logic {S_IDLE, S_WRITE} state_t;

   state_t               state_q, state_d;
   logic [PTR_W-1:0]     wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]     rd_ptr_q, rd_ptr_d;
   logic [PTR_W:0]       count_q, count_d;
   logic                 req_q, req_d;
   logic [ADDR_W-1:0]    addr_q, addr_d;
   logic [COLOR_W-1:0]   data_q, data_d;
   logic                 last_q, last_d;
   logic                 done_q, done_d;
   logic                 busy_q, busy_d;
   logic                 suppress_q, suppress_d;
   logic [ENTRY_W-1:0]   fifo_mem_q [FIFO_DEPTH];

   logic                 fifo_empty, fifo_full, push, pop, clip;
   logic [ADDR_W-1:0]    px_addr;
   logic [ENTRY_W-1:0]   push_entry, head;
   logic                 head_we, head_last;
   logic [ADDR_W-1:0]    head_addr;
   logic [COLOR_W-1:0]   head_color;

   assign fifo_empty = (count_q == '0);
   assign fifo_full  = (count_q == (PTR_W+1)'(FIFO_DEPTH));
   assign px_ready   = !fifo_full && !frame_start;
   assign push       = px_valid && px_ready;

   // Clipped pixels still travel through the FIFO so their last flag can retire the primitive.
   assign clip       = (32'(px_x) >= 32'(H_RES)) || (32'(px_y) >= 32'(V_RES));
   assign px_addr    = ADDR_W'(px_y) * ADDR_W'(H_RES) + ADDR_W'(px_x);
   assign push_entry = {!clip, px_last, px_addr, px_color};

   assign head       = fifo_mem_q[rd_ptr_q];
   assign head_we    = head[ENTRY_W-1];
   assign head_last  = head[ENTRY_W-2];
   assign head_addr  = head[COLOR_W +: ADDR_W];
   assign head_color = head[COLOR_W-1:0];

   assign pop = (state_q == S_IDLE) && !fifo_empty && !frame_start;

   always_comb begin
      state_d    = state_q;
      wr_ptr_d   = wr_ptr_q;
      rd_ptr_d   = rd_ptr_q;
      count_d    = count_q + (PTR_W+1)'(push) - (PTR_W+1)'(pop);
      req_d      = req_q;
      addr_d     = addr_q;
      data_d     = data_q;
      last_d     = last_q;
      done_d     = 1'b0;
      suppress_d = suppress_q;

      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;

      case (state_q)
         S_IDLE: begin
            if (pop) begin
               if (head_we) begin
                  req_d   = 1'b1;
                  addr_d  = head_addr;
                  data_d  = head_color;
                  last_d  = head_last;
                  state_d = S_WRITE;
               end else begin
                  done_d = head_last;
               end
            end
         end
         S_WRITE: begin
            if (mem_ack) begin
               req_d      = 1'b0;
               state_d    = S_IDLE;
               done_d     = last_q && !suppress_q && !frame_start;
               suppress_d = 1'b0;
            end else if (frame_start) begin
               suppress_d = 1'b1;
            end
         end
         default: state_d = S_IDLE;
      endcase

      // A new frame discards queued pixels but lets the in-flight write finish silently.
      if (frame_start) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end

      busy_d = (count_d != '0) || (state_d == S_WRITE);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q    <= S_IDLE;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         count_q    <= '0;
         req_q      <= 1'b0;
         addr_q     <= '0;
         data_q     <= '0;
         last_q     <= 1'b0;
         done_q     <= 1'b0;
         busy_q     <= 1'b0;
         suppress_q <= 1'b0;
      end else begin
         state_q    <= state_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         count_q    <= count_d;
         req_q      <= req_d;
         addr_q     <= addr_d;
         data_q     <= data_d;
         last_q     <= last_d;
         done_q     <= done_d;
         busy_q     <= busy_d;
         suppress_q <= suppress_d;
      end
   end

   always_ff @(posedge clk) begin
      if (push) fifo_mem_q[wr_ptr_q] <= push_entry;
   end

   assign mem_req  = req_q;
   assign mem_addr = addr_q;
   assign mem_data = data_q;
   assign done     = done_q;
   assign busy     = busy_q;

`ifdef PIXEL_STATS_EN
   logic [15:0] written_q, written_d;
   logic [15:0] clipped_q, clipped_d;

   always_comb begin
      written_d = written_q;
      clipped_d = clipped_q;
      if (frame_start) begin
         written_d = '0;
         clipped_d = '0;
      end else begin
         if ((state_q == S_WRITE) && mem_ack && (written_q != 16'hFFFF))
            written_d = written_q + 16'd1;
         if (pop && !head_we && (clipped_q != 16'hFFFF))
            clipped_d = clipped_q + 16'd1;
      end
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         written_q <= '0;
         clipped_q <= '0;
      end else begin
         written_q <= written_d;
         clipped_q <= clipped_d;
      end
   end

   assign written_cnt = written_q;
   assign clipped_cnt = clipped_q;
`endif

endmodule
